regfile_dump_reader: RTL
========================

// Module: regfile_dump_reader
// PURPOSE
//  Debug read-out engine that sits beside the RV32I register file, on the side opposite the writeback path.
//  When requested, and only while the CPU is halted, it takes over one regfile read port.
//  It reads x0..x(NREGS-1) in order and streams each {index, value} beat over a valid/ready channel.
//  The consumer is the board-level debug UART/LED logic. The CPU pipeline is never stalled by this block.
// PARAMETERS
//  NREGS   32  number of registers dumped, starting at x0 (2..32)
//  ADDR_W  5   register index width
//  DATA_W  32  register data width
// PORTS
//  clk          in   1       system clock, all state on rising edge
//  reset_n      in   1       asynchronous, active-low reset
//  start        in   1       1-cycle dump request; ignored while busy=1
//  cpu_halted   in   1       CPU frozen; regfile port may be borrowed only while 1
//  rf_rd_en     out  1       1 = regfile read port address mux selects rf_rd_addr
//  rf_rd_addr   out  ADDR_W  regfile read address
//  rf_rd_data   in   DATA_W  combinational regfile read data for rf_rd_addr
//  busy         out  1       dump in progress (state != IDLE)
//  m_valid      out  1       output beat valid
//  m_ready      in   1       consumer accepts beat
//  m_addr       out  ADDR_W  register index of current beat
//  m_data       out  DATA_W  register value of current beat
//  m_last       out  1       current beat is index NREGS-1
//  done         out  1       1-cycle pulse after final beat is accepted
// BEHAVIOUR
//  Reset (async, any state): state=IDLE, idx=0; all outputs 0.
//   m_addr/m_data/m_last hold 0 until the first capture.
//  States: IDLE, WAIT_HALT, READ, SEND, DONE.
//  IDLE: start=1 -> idx=0, go WAIT_HALT. busy=1 from the next cycle.
//  WAIT_HALT: cpu_halted=1 -> READ; otherwise stay. No timeout.
//  READ (1 cycle): rf_rd_en=1, rf_rd_addr=idx.
//   If cpu_halted=1: capture m_data<=rf_rd_data, m_addr<=idx, m_last<=(idx==NREGS-1); go SEND.
//   If cpu_halted=0: no capture, go WAIT_HALT with idx unchanged.
//  SEND: m_valid=1; rf_rd_en=0. m_addr/m_data/m_last stay stable until m_valid&&m_ready.
//   On handshake with m_last=1 -> DONE.
//   On handshake otherwise: idx<=idx+1, then READ if cpu_halted=1, else WAIT_HALT.
//   m_valid never drops without a handshake, even if cpu_halted falls.
//  DONE (1 cycle): done=1, busy=1; then IDLE, idx=0.
//  rf_rd_en is 1 only in READ. rf_rd_addr=idx in every state; the regfile mux ignores it when rf_rd_en=0.
//  x0 value is whatever the regfile returns; it is expected to be 0 and is not forced here.
//  Throughput: 2 cycles/beat minimum with m_ready tied 1.
//   Full 32-reg dump = 1 (IDLE->WAIT_HALT) + 1 (WAIT_HALT) + 64 + 1 (DONE) cycles.
//  idx never exceeds NREGS-1; there is no wrap.
//  start arriving in the DONE cycle is ignored; start in IDLE is taken even if done pulsed the cycle before.
//  reset_n low mid-beat drops m_valid immediately and does not complete the handshake.
// TESTING
//  1 Regfile xN=0x100+N (x0=0), cpu_halted=1, m_ready=1, start pulse
//    -> 32 beats, m_addr 0..31, m_data 0,0x101..0x11F; m_last only on beat 31;
//       done pulses once; busy low 67 cycles after start.
//  2 Random m_ready backpressure (~50%)
//    -> m_addr/m_data/m_valid stable while !m_ready; no beat lost or duplicated; same 32-beat sequence.
//  3 cpu_halted=0 at start, raised 10 cycles later
//    -> no rf_rd_en and no m_valid before halt; first beat m_addr=0 afterwards.
//  4 Drop cpu_halted during SEND of beat 5 and hold m_ready=0 two cycles
//    -> beat 5 completes unchanged; engine waits in WAIT_HALT;
//       after re-halt, next beat m_addr=6 with correct data.
//  5 Pulse start while busy, including the DONE cycle
//    -> ignored: exactly 32 beats and one done pulse.
//  6 Assert reset_n low while m_valid=1 on beat 12
//    -> all outputs 0 immediately; after release, a new start dumps from m_addr=0.

Source files
------------

// File: rtl/regfile_dump_reader.sv
// rtl/regfile_dump_reader.sv - debug engine that streams x0..x(NREGS-1) while the CPU is halted
//
// Ports:
//   clk, reset_n            clock and asynchronous active-low reset
//   start                   one-cycle dump request, ignored while busy
//   cpu_halted              regfile read port may only be borrowed while high
//   rf_rd_en, rf_rd_addr    borrowed regfile read port (address mux select, address)
//   rf_rd_data              combinational regfile data for rf_rd_addr
//   busy                    dump in progress
//   m_valid, m_ready        output beat handshake
//   m_addr, m_data, m_last  beat payload: register index, value, final-register flag
//   done                    one-cycle pulse after the final beat is accepted
module regfile_dump_reader #(
  parameter int unsigned NREGS  = 32,
  parameter int unsigned ADDR_W = 5,
  parameter int unsigned DATA_W = 32
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              start,
  input  logic              cpu_halted,
  output logic              rf_rd_en,
  output logic [ADDR_W-1:0] rf_rd_addr,
  input  logic [DATA_W-1:0] rf_rd_data,
  output logic              busy,
  output logic              m_valid,
  input  logic              m_ready,
  output logic [ADDR_W-1:0] m_addr,
  output logic [DATA_W-1:0] m_data,
  output logic              m_last,
  output logic              done
);

  typedef enum logic [2:0] {
    IDLE,
    WAIT_HALT,
    READ,
    SEND,
    DONE
  } state_t;

  localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(NREGS - 1);

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] idx_q, idx_d;
  logic              capture;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      idx_q   <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
    end
  end

  // Beat payload is only loaded in READ, so it stays frozen for the whole
  // SEND phase regardless of what the CPU does to cpu_halted.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      m_addr <= '0;
      m_data <= '0;
      m_last <= 1'b0;
    end else if (capture) begin
      m_addr <= idx_q;
      m_data <= rf_rd_data;
      m_last <= (idx_q == LAST_IDX);
    end
  end

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    capture = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          idx_d   = '0;
          state_d = WAIT_HALT;
        end
      end
      WAIT_HALT: begin
        if (cpu_halted) state_d = READ;
      end
      READ: begin
        // Halt may have dropped since WAIT_HALT; never capture from a live CPU.
        if (cpu_halted) begin
          capture = 1'b1;
          state_d = SEND;
        end else begin
          state_d = WAIT_HALT;
        end
      end
      SEND: begin
        if (m_ready) begin
          if (m_last) begin
            state_d = DONE;
          end else begin
            idx_d   = idx_q + ADDR_W'(1);
            state_d = cpu_halted ? READ : WAIT_HALT;
          end
        end
      end
      DONE: begin
        idx_d   = '0;
        state_d = IDLE;
      end
      default: begin
        idx_d   = '0;
        state_d = IDLE;
      end
    endcase
  end

  assign rf_rd_en   = (state_q == READ);
  assign rf_rd_addr = idx_q;
  assign busy       = (state_q != IDLE);
  assign m_valid    = (state_q == SEND);
  assign done       = (state_q == DONE);

endmodule
